// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the shared memory and the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              if_stall;
   logic              d_rd;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              d_stall;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the data port.
// Data wins arbitration; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clock,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);
   localparam logic [3:0] STV    = 4'(STARVE_LIMIT);

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cnt;
   logic [3:0]        r_starve;
   logic              r_gnt_d;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              w_d_req;
   logic              w_gnt_d;
   logic              w_gnt_if;
   logic              w_resp;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Requests are only looked at in IDLE; later changes on the inputs are ignored.
   always_comb begin
      w_next   = r_state;
      w_gnt_d  = 1'b0;
      w_gnt_if = 1'b0;
      w_d_req  = bus.d_rd | bus.d_wr;
      case (r_state)
         IDLE: begin
            if (w_d_req && !(bus.if_req && r_starve == STV)) begin
               w_gnt_d = 1'b1;
               w_next  = ISSUE;
            end else if (bus.if_req) begin
               w_gnt_if = 1'b1;
               w_next   = ISSUE;
            end
         end
         ISSUE:   w_next = WAIT;
         WAIT:    if (r_cnt == 4'd0) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt      <= '0;
         r_starve   <= '0;
         r_gnt_d    <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
      end else begin
         if (w_gnt_d) begin
            r_gnt_d <= 1'b1;
            r_addr  <= bus.d_addr;
            r_wdata <= bus.d_wdata;
            // rd+wr together is resolved as a write
            r_we    <= bus.d_wr;
            if (!bus.if_req)          r_starve <= '0;
            else if (r_starve < STV)  r_starve <= r_starve + 4'd1;
         end
         if (w_gnt_if) begin
            r_gnt_d  <= 1'b0;
            r_addr   <= bus.if_addr;
            r_we     <= 1'b0;
            r_starve <= '0;
         end
         if (r_state == ISSUE) r_cnt <= LAT_M1;
         if (r_state == WAIT) begin
            if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            else if (!r_we) begin
               if (r_gnt_d) r_d_rdata  <= bus.mem_rdata;
               else         r_if_rdata <= bus.mem_rdata;
            end
         end
      end
   end

   assign w_resp        = (r_state == RESP);
   assign bus.mem_en    = (r_state == ISSUE);
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.if_ready  = w_resp & ~r_gnt_d;
   assign bus.d_ready   = w_resp & r_gnt_d;
   assign bus.if_stall  = bus.if_req & ~bus.if_ready;
   assign bus.d_stall   = (bus.d_rd | bus.d_wr) & ~bus.d_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (latency 1 / starve 4 and latency 3 / starve 2) driven by randomized requesters,
// compared each cycle against a transaction-timing reference model.
module tb_mem_port_arbiter;
   localparam int END_CYC = 1700;

   typedef struct packed {
      logic        if_ready, d_ready, if_stall, d_stall, mem_en, mem_we;
      logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   } obs_t;

   typedef struct packed {
      logic        if_req, d_rd, d_wr;
      logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   } inp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4))
      u_dut0 (.clock(clock), .reset(reset), .bus(bus0));
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_LIMIT(2))
      u_dut1 (.clock(clock), .reset(reset), .bus(bus1));

   obs_t obs [2];
   inp_t inp [2];

   assign obs[0] = {bus0.if_ready, bus0.d_ready, bus0.if_stall, bus0.d_stall, bus0.mem_en,
                    bus0.mem_we, bus0.if_rdata, bus0.d_rdata, bus0.mem_addr, bus0.mem_wdata};
   assign obs[1] = {bus1.if_ready, bus1.d_ready, bus1.if_stall, bus1.d_stall, bus1.mem_en,
                    bus1.mem_we, bus1.if_rdata, bus1.d_rdata, bus1.mem_addr, bus1.mem_wdata};
   assign {bus0.if_req, bus0.d_rd, bus0.d_wr, bus0.if_addr, bus0.d_addr, bus0.d_wdata,
           bus0.mem_rdata} = inp[0];
   assign {bus1.if_req, bus1.d_rd, bus1.d_wr, bus1.if_addr, bus1.d_addr, bus1.d_wdata,
           bus1.mem_rdata} = inp[1];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic string tg(input int i, input string s);
      return $sformatf("u%0d.%s", i, s);
   endfunction

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic int stv_of(input int i);
      return (i == 0) ? 4 : 2;
   endfunction

   function automatic logic [31:0] init_word(input int a);
      if (a == 32'h10) return 32'h8C22_0004;
      if (a == 32'h40) return 32'h0000_ABCD;
      return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   // reference model: one outstanding transaction with fixed timing
   bit          pv [2];
   bit          pport_d [2];
   bit          pwe [2];
   int          iss [2], rdy [2], busy_until [2], starve [2];
   logic [31:0] paddr [2], pwdata [2], pdata [2];
   logic [31:0] e_if_rdata [2], e_d_rdata [2], e_maddr [2], e_mwdata [2];
   logic        e_mwe [2], e_ir [2], e_dr [2];
   logic [31:0] shadow [2][256];
   // environment: memory, requesters, starvation observer
   logic [31:0] envm [2][256];
   bit          ev [2];
   int          edue [2];
   logic [31:0] edat [2];
   bit          qi_v [2], qd_v [2], qd_rd [2], qd_wr [2];
   logic [31:0] qi_a [2], qd_a [2], qd_w [2];
   int          drun [2];
   bit          seen_if [2];
   bit          did_rst;
   int          rst_rel;

   task automatic model_reset(input int i);
      pv[i] = 0; busy_until[i] = 0; starve[i] = 0;
      e_if_rdata[i] = '0; e_d_rdata[i] = '0; e_maddr[i] = '0; e_mwdata[i] = '0; e_mwe[i] = 1'b0;
   endtask

   task automatic model_update(input int i, input int c);
      bit gd, gi;
      gd = 0; gi = 0;
      if (c < busy_until[i]) return;
      if ((inp[i].d_rd || inp[i].d_wr) && !(inp[i].if_req && starve[i] >= stv_of(i))) gd = 1;
      else if (inp[i].if_req) gi = 1;
      if (gd) begin
         pport_d[i] = 1; pwe[i] = inp[i].d_wr; paddr[i] = inp[i].d_addr;
         pwdata[i] = inp[i].d_wdata; e_mwdata[i] = inp[i].d_wdata;
         starve[i] = inp[i].if_req ? ((starve[i] + 1 > stv_of(i)) ? stv_of(i) : starve[i] + 1) : 0;
      end
      if (gi) begin
         pport_d[i] = 0; pwe[i] = 0; paddr[i] = inp[i].if_addr; starve[i] = 0;
      end
      if (gd || gi) begin
         pv[i] = 1; iss[i] = c + 1; rdy[i] = c + lat_of(i) + 2; busy_until[i] = c + lat_of(i) + 3;
         e_maddr[i] = paddr[i]; e_mwe[i] = pwe[i];
      end
   endtask

   task automatic step(input int i, input int c);
      int pi, pd, k;
      if (pv[i] && c == iss[i]) begin
         if (pwe[i]) shadow[i][paddr[i][7:0]] = pwdata[i];
         else        pdata[i] = shadow[i][paddr[i][7:0]];
      end
      if (pv[i] && c == rdy[i] && !pwe[i]) begin
         if (pport_d[i]) e_d_rdata[i] = pdata[i];
         else            e_if_rdata[i] = pdata[i];
      end
      e_ir[i] = pv[i] && c == rdy[i] && !pport_d[i];
      e_dr[i] = pv[i] && c == rdy[i] && pport_d[i];
      chk(tg(i, "if_ready"), obs[i].if_ready, e_ir[i]);
      chk(tg(i, "d_ready"), obs[i].d_ready, e_dr[i]);
      chk(tg(i, "mem_en"), obs[i].mem_en, pv[i] && c == iss[i]);
      chk(tg(i, "mem_addr"), obs[i].mem_addr, e_maddr[i]);
      chk(tg(i, "mem_we"), obs[i].mem_we, e_mwe[i]);
      chk(tg(i, "mem_wdata"), obs[i].mem_wdata, e_mwdata[i]);
      chk(tg(i, "if_rdata"), obs[i].if_rdata, e_if_rdata[i]);
      chk(tg(i, "d_rdata"), obs[i].d_rdata, e_d_rdata[i]);
      if (pv[i] && c == rdy[i]) pv[i] = 0;

      // both ports permanently busy: every fetch grant follows exactly STARVE_LIMIT data grants
      if (c >= 70 && c < 300) begin
         if (obs[i].d_ready) drun[i]++;
         if (obs[i].if_ready) begin
            if (seen_if[i]) chk(tg(i, "starve_run"), drun[i], stv_of(i));
            seen_if[i] = 1;
            drun[i] = 0;
         end
      end

      if (obs[i].mem_en) begin
         if (obs[i].mem_we) envm[i][obs[i].mem_addr[7:0]] = obs[i].mem_wdata;
         else begin
            ev[i] = 1; edue[i] = c + lat_of(i); edat[i] = envm[i][obs[i].mem_addr[7:0]];
         end
      end

      if (obs[i].if_ready) qi_v[i] = 0;
      if (obs[i].d_ready)  qd_v[i] = 0;
      if (c == 5)  begin qi_v[i] = 1; qi_a[i] = 32'h10; end
      if (c == 15) begin
         qi_v[i] = 1; qi_a[i] = 32'h4;
         qd_v[i] = 1; qd_rd[i] = 1; qd_wr[i] = 0; qd_a[i] = 32'h40;
      end
      if (c == 35) begin qd_v[i] = 1; qd_rd[i] = 0; qd_wr[i] = 1; qd_a[i] = 32'h20; qd_w[i] = 32'hDEAD_BEEF; end
      if (c == 45) begin qd_v[i] = 1; qd_rd[i] = 1; qd_wr[i] = 0; qd_a[i] = 32'h20; end
      pi = 0; pd = 0;
      if (c >= 60 && c < 300)        begin pi = 100; pd = 100; end
      else if (c >= 300 && c < 900)  begin pi = 60;  pd = 50;  end
      else if (c >= 900 && c < 1600) begin pi = 30;  pd = 80;  end
      if (!qi_v[i] && int'($urandom_range(0, 99)) < pi) begin
         qi_v[i] = 1; qi_a[i] = 32'($urandom_range(0, 255));
      end
      if (!qd_v[i] && int'($urandom_range(0, 99)) < pd) begin
         k = int'($urandom_range(0, 7));
         qd_v[i] = 1; qd_wr[i] = (k <= 3); qd_rd[i] = (k == 0 || k >= 4);
         qd_a[i] = 32'($urandom_range(0, 255)); qd_w[i] = $urandom;
      end

      // once granted, the request payload wanders; the latched copy must be used
      inp[i].if_req    = qi_v[i];
      inp[i].if_addr   = (pv[i] && !pport_d[i]) ? $urandom : qi_a[i];
      inp[i].d_rd      = qd_v[i] && qd_rd[i];
      inp[i].d_wr      = qd_v[i] && qd_wr[i];
      inp[i].d_addr    = (pv[i] && pport_d[i]) ? $urandom : qd_a[i];
      inp[i].d_wdata   = (pv[i] && pport_d[i]) ? $urandom : qd_w[i];
      inp[i].mem_rdata = (ev[i] && edue[i] == c) ? edat[i] : $urandom;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < 256; a++) begin
            envm[i][a]   = init_word(a);
            shadow[i][a] = init_word(a);
         end
         model_reset(i);
         qi_v[i] = 0; qd_v[i] = 0; qd_rd[i] = 0; qd_wr[i] = 0;
         qi_a[i] = '0; qd_a[i] = '0; qd_w[i] = '0;
         ev[i] = 0; edue[i] = -1; edat[i] = '0; drun[i] = 0; seen_if[i] = 0;
         iss[i] = -1; rdy[i] = -1; pport_d[i] = 0; pwe[i] = 0; paddr[i] = '0; pwdata[i] = '0;
         pdata[i] = '0;
         inp[i] = '0;
      end
      did_rst = 0;
      rst_rel = 3;
      for (int c = 0; c < END_CYC; c++) begin
         @(negedge clock);
         if (!reset && c == rst_rel) reset = 1'b1;
         // abort the latency-1 arbiter in its WAIT cycle
         if (reset && !did_rst && c >= 1000 && pv[0] && c > iss[0] && c < rdy[0]) begin
            reset = 1'b0; did_rst = 1; rst_rel = c + 3;
            for (int i = 0; i < 2; i++) model_reset(i);
         end
         #1;
         for (int i = 0; i < 2; i++) step(i, c);
         #1;
         for (int i = 0; i < 2; i++) begin
            chk(tg(i, "if_stall"), obs[i].if_stall, inp[i].if_req & ~e_ir[i]);
            chk(tg(i, "d_stall"), obs[i].d_stall, (inp[i].d_rd | inp[i].d_wr) & ~e_dr[i]);
            if (reset) model_update(i, c);
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
